muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state enum and a small op decode helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULU = 2'b00,
        DIVU = 2'b01,
        MUL  = 2'b10,
        DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Bit 0 of the op code separates divides from multiplies.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle of the multiply/divide unit.
// master = requester side, slave = the unit itself.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by both datapaths.
// Multiply: conditional add of m into acc, then shift {acc,q} right.
// Divide:   shift {acc,q} left one bit, trial-subtract m, restore on borrow.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Single shift/add-or-subtract step; diff[WIDTH] is the borrow of the trial subtract.
    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        sum     = {1'b0, acc} + {1'b0, m};
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            {acc_nxt, q_nxt} = {sum, q[WIDTH-1:1]};
        end else begin
            {acc_nxt, q_nxt} = {1'b0, acc, q[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit, one bit per RUN cycle.
// Build option: define MULDIV_SIGNED_EN to honour op[1] (signed MUL/DIV)
// and include the sign-correction logic in FIX; otherwise all ops are unsigned.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | first cycle checks divide-by-zero, then WIDTH iterations (down-counter)
// FIX   | sign correction and result write; done pulses on the exit edge
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, m_q, a_q;
    logic             op_div_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dz_q, done_q;
    logic             accept, step_en, fix_wr, div_zero_w;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign div_zero_w = op_div_q && (m_q == '0);

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_div_q),
        .acc     (acc_q),
        .q       (q_q),
        .m       (m_q),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath strobes; flush beats start and aborts RUN/FIX.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step_en = 1'b0;
        fix_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flush)                         state_d = IDLE;
                else if (div_zero_w || cnt_q == '0)    state_d = FIX;
                else                                   step_en = 1'b1;
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) fix_wr = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; without signed support the raw operands are used.
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
`ifdef MULDIV_SIGNED_EN
        if (bus.op[1] && bus.a[WIDTH-1]) mag_a = -bus.a;
        if (bus.op[1] && bus.b[WIDTH-1]) mag_b = -bus.b;
`endif
    end

`ifdef MULDIV_SIGNED_EN
    logic             neg_res_q, neg_rem_q;
    logic [2*WIDTH-1:0] prod_neg;

    // Result sign flags latched with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_res_q <= bus.op[1] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_q <= bus.op[1] & bus.a[WIDTH-1];
        end
    end
`endif

    // Final result as written in FIX; divide-by-zero overrides everything.
    always_comb begin
        res_hi = acc_q;
        res_lo = q_q;
`ifdef MULDIV_SIGNED_EN
        prod_neg = -{acc_q, q_q};
        if (!op_div_q && neg_res_q) {res_hi, res_lo} = prod_neg;
        if (op_div_q && neg_res_q)  res_lo = -q_q;
        if (op_div_q && neg_rem_q)  res_hi = -acc_q;
`endif
        if (div_zero_w) begin
            res_hi = a_q;
            res_lo = '1;
        end
    end

    // Operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            op_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fix_wr;
            if (accept) begin
                cnt_q    <= CNT_W'(WIDTH);
                acc_q    <= '0;
                a_q      <= bus.a;
                op_div_q <= op_is_div(bus.op);
                q_q      <= op_is_div(bus.op) ? mag_a : mag_b;
                m_q      <= op_is_div(bus.op) ? mag_b : mag_a;
            end
            if (step_en) begin
                acc_q <= acc_nxt;
                q_q   <= q_nxt;
                cnt_q <= cnt_q - 1'b1;
            end
            if (fix_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                dz_q <= div_zero_w;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): fixed vectors, corner sequences,
// and random operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
        longint      sx, sy, qq, rr;
        logic [63:0] p;
        bit          sgn;
        sgn = SGN && o[1];
        sx  = sgn ? longint'($signed(x)) : longint'({32'h0, x});
        sy  = sgn ? longint'($signed(y)) : longint'({32'h0, y});
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        if (o[0] && y == '0) begin
            eh  = x;
            el  = '1;
            edz = 1'b1;
        end else if (o[0]) begin
            qq = sx / sy;
            rr = sx % sy;
            el = qq[W-1:0];
            eh = rr[W-1:0];
        end else begin
            p  = sx * sy;
            eh = p[2*W-1:W];
            el = p[W-1:0];
        end
    endfunction

    // Present a request and let one edge accept it; inputs are then scrambled.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait (bounded) for done; k0 = edges already elapsed since the start edge.
    task automatic finish_op(input string nm, input int k0, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input logic edz, input int elat);
        int lat;
        bit busy_ok;
        bit busy_at_done;
        lat          = 0;
        busy_at_done = 1'b1;
        busy_ok      = (bus.busy === 1'b1) && (bus.done === 1'b0);
        for (int k = k0 + 1; k <= k0 + 100; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat          = k;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " busy_in_flight"}, 64'(busy_ok), 64'd1);
        chk({nm, " busy_at_done"}, 64'(busy_at_done), 64'd0);
        chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, " lo"}, 64'(bus.lo), 64'(el));
        chk({nm, " div_zero"}, 64'(bus.div_zero), 64'(edz));
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] eh, el;
        logic         edz;
        logic [1:0]   o;
        logic [W-1:0] x, y;
        int           n;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[1] = '{DIV,  32'hFFFFFFF9, 32'h00000002,
                    SGN ? 32'hFFFFFFFF : 32'h00000001,
                    SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0, 34};
        vecs[2] = '{DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 2};
        vecs[3] = '{DIV,  32'h80000000, 32'hFFFFFFFF,
                    SGN ? 32'h00000000 : 32'h80000000,
                    SGN ? 32'h80000000 : 32'h00000000, 1'b0, 34};
        vecs[4] = '{MULU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34};
        vecs[5] = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34};
        vecs[6] = '{MUL,  32'hFFFFFFFD, 32'd5,
                    SGN ? 32'hFFFFFFFF : 32'h00000004, 32'hFFFFFFF1, 1'b0, 34};
        vecs[7] = '{DIV,  32'd7, 32'hFFFFFFFE,
                    SGN ? 32'd1 : 32'd7,
                    SGN ? 32'hFFFFFFFD : 32'd0, 1'b0, 34};
        vecs[8] = '{DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
        vecs[9] = '{DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 34};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed vectors, each followed by a check that done drops and results hold.
        foreach (vecs[i]) begin
            @(negedge clk);
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), 0, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d done_pulse", i), 64'(bus.done), 64'd0);
            chk($sformatf("vec%0d hold_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d hold_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
        end

        // Flush 10 cycles into a multiply: no done, previous results kept.
        @(negedge clk);
        launch(MULU, 32'd6, 32'd7);
        finish_op("pre_flush", 0, 32'd0, 32'd42, 1'b0, 34);
        @(negedge clk);
        launch(MULU, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush busy", 64'(bus.busy), 64'd0);
        chk("flush done", 64'(bus.done), 64'd0);
        chk("flush hi", 64'(bus.hi), 64'd0);
        chk("flush lo", 64'(bus.lo), 64'd42);
        count_dones(40, n);
        chk("flush no_done", 64'(n), 64'd0);
        model(DIVU, 32'd1000, 32'd33, eh, el, edz);
        launch(DIVU, 32'd1000, 32'd33);
        finish_op("post_flush", 0, eh, el, edz, 34);

        // Flush together with start in IDLE drops the start.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MULU;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start busy", 64'(bus.busy), 64'd0);
        count_dones(40, n);
        chk("flush_start no_done", 64'(n), 64'd0);

        // Second start while busy is ignored.
        @(negedge clk);
        launch(MULU, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        finish_op("busy_start", 6, 32'd0, 32'd15, 1'b0, 34);
        count_dones(40, n);
        chk("busy_start single_done", 64'(n), 64'd0);

        // Reset mid-operation clears everything, no done afterwards.
        @(negedge clk);
        launch(MULU, 32'hFFFF0000, 32'h0000FFFF);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst busy", 64'(bus.busy), 64'd0);
        chk("mid_rst hi", 64'(bus.hi), 64'd0);
        chk("mid_rst lo", 64'(bus.lo), 64'd0);
        chk("mid_rst div_zero", 64'(bus.div_zero), 64'd0);
        count_dones(40, n);
        chk("mid_rst no_done", 64'(n), 64'd0);

        // Random operations; a zero gap launches during the done cycle (back-to-back).
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom);
            model(o, x, y, eh, el, edz);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            launch(o, x, y);
            finish_op($sformatf("rnd%0d", i), 0, eh, el, edz, (o[0] && y == '0) ? 2 : 34);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
